// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the interrupt controller and CSR unit
package intr_pkg;

    // Default number of external interrupt sources
    localparam int NUM_SRC_DEF = 4;

    // Machine-mode CSR addresses shared with the CSR unit
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;

    // MSTATUS bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Controller state: idle (trap allowed) or servicing an interrupt
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } state_t;

    // Width of a source index; a single source still needs one bit
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intr_ctrl_irq_sync_edge.sv
// rtl/intr_ctrl_irq_sync_edge.sv - one source: 2-flop synchroniser, previous-value flop, registered rising-edge pulse
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;
    logic w_edge;

    // A level held high gives exactly one pulse: sync2 high while prev still low
    assign w_edge = r_sync2 & ~r_prev;
    assign o_edge = r_edge;

    // Synchronise the asynchronous line, remember the last value, register the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= w_edge;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller sequencing machine-mode trap entry and MRET exit
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = id_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               mie,
    input  logic               mtvec_ready,
    input  logic               at_boundary,
    input  logic               do_mret,
    output logic               take_intr,
    output logic [ID_W-1:0]    intr_id,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pending
);

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_SRC-1:0] r_pending;
    logic [ID_W-1:0]    r_intr_id;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_claim;
    logic [ID_W-1:0]    w_sel;
    logic               w_take;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            irq_sync_edge u_sync (
                .clk    (clk),
                .rst    (rst),
                .i_irq  (irq_src[g]),
                .o_edge (w_edge[g])
            );
        end
    endgenerate

    // Masked sources stay latched but cannot be selected
    assign w_eligible = r_pending & irq_en;

    // Fixed-priority arbiter: lowest set index of eligible wins
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    assign w_claim = w_take ? (NUM_SRC'(1) << w_sel) : '0;

    // Next state and the Mealy take pulse; ISR blocks nesting
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_eligible != '0) && mie && mtvec_ready && at_boundary) begin
                    w_take       = 1'b1;
                    w_next_state = ST_ISR;
                end
            end
            ST_ISR: begin
                if (do_mret) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pending latch: a new edge beats a simultaneous claim so no event is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_claim) | w_edge;
        end
    end

    // Capture the serviced source index; held until the next take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_intr_id <= '0;
        end else if (w_take) begin
            r_intr_id <= w_sel;
        end
    end

    assign take_intr = w_take;
    assign intr_id   = r_intr_id;
    assign in_isr    = (r_state == ST_ISR);
    assign pending   = r_pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl
module tb_intr_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_src;
    logic [3:0] irq_en;
    logic       mie;
    logic       mtvec_ready;
    logic       at_boundary;
    logic       do_mret;
    logic       take_intr;
    logic [1:0] intr_id;
    logic       in_isr;
    logic [3:0] pending;

    int         tests;
    int         fails;
    int         takes;
    logic [1:0] exp_q[$];

    intr_ctrl #(.NUM_SRC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .irq_en      (irq_en),
        .mie         (mie),
        .mtvec_ready (mtvec_ready),
        .at_boundary (at_boundary),
        .do_mret     (do_mret),
        .take_intr   (take_intr),
        .intr_id     (intr_id),
        .in_isr      (in_isr),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse a source for one cycle starting before the next edge
    task automatic pulse(input int src);
        irq_src[src] = 1'b1;
        step(1);
        irq_src[src] = 1'b0;
    endtask

    // Model the CSR unit: MIE dropped in ISR, MRET, MIE restored a cycle later
    task automatic do_return();
        mie     = 1'b0;
        do_mret = 1'b1;
        step(1);
        do_mret = 1'b0;
        check("idle_after_mret", {31'd0, in_isr}, 32'd0);
    endtask

    // Monitor: every take pops an expected id and checks it the following cycle
    always @(negedge clk) begin
        if (take_intr) begin
            logic [1:0] e;
            takes++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_take: got take_intr=1 expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                @(negedge clk);
                check("sb_intr_id", {30'd0, intr_id}, {30'd0, e});
                check("sb_in_isr", {31'd0, in_isr}, 32'd1);
            end
        end
    end

    initial begin
        int t0;
        tests = 0; fails = 0; takes = 0;
        rst = 1'b1; irq_src = '0; irq_en = '0; mie = 1'b0;
        mtvec_ready = 1'b0; at_boundary = 1'b0; do_mret = 1'b0;
        step(2);
        check("rst_in_isr", {31'd0, in_isr}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_intr_id", {30'd0, intr_id}, 32'd0);
        check("rst_take", {31'd0, take_intr}, 32'd0);
        rst = 1'b0;
        mtvec_ready = 1'b1; mie = 1'b1; irq_en = 4'b1111; at_boundary = 1'b1;
        step(1);

        // 1. basic take on source 2
        pulse(2);                       // now after edge 0
        step(2);                        // after edge 2
        check("t1_pend_e2", {28'd0, pending}, 32'd0);
        exp_q.push_back(2'd2);
        step(1);                        // after edge 3
        check("t1_pend_e3", {28'd0, pending}, 32'h4);
        check("t1_take_e3", {31'd0, take_intr}, 32'd1);
        step(1);                        // after edge 4
        check("t1_in_isr", {31'd0, in_isr}, 32'd1);
        check("t1_pend_clr", {28'd0, pending}, 32'd0);
        check("t1_take_once", {31'd0, take_intr}, 32'd0);
        do_return();
        mie = 1'b1;

        // 2. priority between sources 3 and 1
        irq_src = 4'b1010;
        step(1);
        irq_src = 4'b0000;
        exp_q.push_back(2'd1);
        step(3);
        check("t2_take", {31'd0, take_intr}, 32'd1);
        step(1);
        check("t2_pend_held", {28'd0, pending}, 32'h8);
        t0 = takes;
        step(5);
        check("t2_no_nest", takes, t0);
        check("t2_pend_isr", {28'd0, pending}, 32'h8);
        do_return();
        exp_q.push_back(2'd3);
        mie = 1'b1;
        step(1);
        check("t2_second", {31'd0, in_isr}, 32'd1);
        check("t2_pend_empty", {28'd0, pending}, 32'd0);
        do_return();
        mie = 1'b1;

        // 3. mtvec_ready gating, then boundary hold
        mtvec_ready = 1'b0;
        t0 = takes;
        pulse(0);
        step(4);
        check("t3_pend", {28'd0, pending}, 32'h1);
        step(50);
        check("t3_no_take", takes, t0);
        check("t3_pend_keep", {28'd0, pending}, 32'h1);
        at_boundary = 1'b0;
        mtvec_ready = 1'b1;
        step(3);
        check("t3_wait_bnd", takes, t0);
        exp_q.push_back(2'd0);
        at_boundary = 1'b1;
        step(1);
        check("t3_taken", {31'd0, in_isr}, 32'd1);
        do_return();
        mie = 1'b1;

        // 4. masked source
        irq_en = 4'b1101;
        t0 = takes;
        pulse(1);
        step(5);
        check("t4_pend", {28'd0, pending}, 32'h2);
        check("t4_no_take", takes, t0);
        exp_q.push_back(2'd1);
        irq_en = 4'b1111;
        step(1);
        check("t4_taken", {31'd0, in_isr}, 32'd1);
        do_return();
        mie = 1'b1;

        // 5. new edge on source 0 during its own claim cycle
        at_boundary = 1'b0;
        pulse(0);                       // after edge 0
        step(3);                        // after edge 3
        check("t5_pend_first", {28'd0, pending}, 32'h1);
        pulse(0);                       // second rise sampled at edge 4
        step(2);                        // after edge 6: edge pulse active now
        exp_q.push_back(2'd0);
        at_boundary = 1'b1;
        step(1);                        // after edge 7
        check("t5_set_wins", {28'd0, pending}, 32'h1);
        check("t5_in_isr", {31'd0, in_isr}, 32'd1);
        do_return();
        exp_q.push_back(2'd0);
        mie = 1'b1;
        step(1);
        check("t5_reentry", {31'd0, in_isr}, 32'd1);
        check("t5_pend_clr", {28'd0, pending}, 32'd0);
        do_return();
        mie = 1'b1;

        // 6. reset while in ISR with source 1 pending
        exp_q.push_back(2'd2);
        pulse(2);
        step(4);
        check("t6_isr", {31'd0, in_isr}, 32'd1);
        pulse(1);
        step(4);
        check("t6_pend", {28'd0, pending}, 32'h2);
        rst = 1'b1;
        #1;
        check("t6_rst_isr", {31'd0, in_isr}, 32'd0);
        check("t6_rst_pend", {28'd0, pending}, 32'd0);
        check("t6_rst_id", {30'd0, intr_id}, 32'd0);
        check("t6_rst_take", {31'd0, take_intr}, 32'd0);
        step(1);
        rst = 1'b0;
        t0 = takes;
        step(10);
        check("t6_no_take", takes, t0);
        exp_q.push_back(2'd3);
        pulse(3);
        step(4);
        check("t6_new_take", {31'd0, in_isr}, 32'd1);
        do_return();

        step(3);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
